// File: rtl/avl_rr_arbiter.sv
// Two-requester round-robin arbiter onto a single Avalon-MM DDR3 port.
// Read tags are queued in issue order and steer avl_readdatavalid back to the issuer.
module avl_rr_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 8
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         local_init_done,

  input  logic [ADDR_W-1:0]            r0_address,
  input  logic [DATA_W-1:0]            r0_writedata,
  input  logic                         r0_read,
  input  logic                         r0_write,
  output logic                         r0_waitrequest_n,
  output logic                         r0_readdatavalid,

  input  logic [ADDR_W-1:0]            r1_address,
  input  logic [DATA_W-1:0]            r1_writedata,
  input  logic                         r1_read,
  input  logic                         r1_write,
  output logic                         r1_waitrequest_n,
  output logic                         r1_readdatavalid,

  output logic [DATA_W-1:0]            rd_data,

  output logic [ADDR_W-1:0]            avl_address,
  output logic [DATA_W-1:0]            avl_writedata,
  output logic                         avl_read,
  output logic                         avl_write,
  output logic                         avl_burstbegin,
  input  logic                         avl_waitrequest_n,
  input  logic                         avl_readdatavalid,
  input  logic [DATA_W-1:0]            avl_readdata,

  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err_underflow
);

  // state  | meaning
  // IDLE   | no owner; pick next requester (round-robin on ties)
  // GRANT0 | requester 0 drives avl_*; leave on accept or request drop
  // GRANT1 | requester 1 drives avl_*; leave on accept or request drop

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               first_cycle;

  logic               tag_mem [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               own_read;
  logic               own_write;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic               req0;
  logic               req1;
  logic               fifo_full;
  logic               fifo_empty;
  logic               cmd;
  logic               accept;
  logic               push;
  logic               pop;
  logic               head_tag;

  assign req0 = r0_read | r0_write;
  assign req1 = r1_read | r1_write;

  always_comb begin
    own_read  = 1'b0;
    own_write = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state)
      GRANT0: begin
        own_read  = r0_read;
        own_write = r0_write;
        own_addr  = r0_address;
        own_wdata = r0_writedata;
      end
      GRANT1: begin
        own_read  = r1_read;
        own_write = r1_write;
        own_addr  = r1_address;
        own_wdata = r1_writedata;
      end
      default: ;
    endcase
  end

  assign fifo_full  = (count == CNT_W'(MAX_OUTST));
  assign fifo_empty = (count == '0);

  // Write wins over a simultaneous read; a read may only issue if a tag slot is free.
  assign avl_write      = own_write;
  assign avl_read       = own_read & ~own_write & ~fifo_full;
  assign avl_address    = own_addr;
  assign avl_writedata  = own_wdata;
  assign cmd            = avl_read | avl_write;
  assign avl_burstbegin = first_cycle & cmd;

  assign accept           = avl_waitrequest_n & cmd;
  assign r0_waitrequest_n = (state == GRANT0) & accept;
  assign r1_waitrequest_n = (state == GRANT1) & accept;

  assign push     = accept & avl_read;
  assign pop      = avl_readdatavalid & ~fifo_empty;
  assign head_tag = tag_mem[rd_ptr];

  assign r0_readdatavalid = pop & ~head_tag;
  assign r1_readdatavalid = pop &  head_tag;
  assign rd_data          = avl_readdata;
  assign outstanding      = count;

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      first_cycle <= 1'b0;
    end else begin
      first_cycle <= 1'b0;
      case (state)
        IDLE: begin
          if (local_init_done && (req0 || req1)) begin
            first_cycle <= 1'b1;
            if (req0 && (!req1 || last_grant)) state <= GRANT0;
            else                               state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            last_grant <= (state == GRANT1);
            state      <= IDLE;
          end else if (!own_read && !own_write) begin
            // Requester abandoned its request; round-robin history is kept as is.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (avl_readdatavalid && fifo_empty) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) tag_mem[wr_ptr] <= (state == GRANT1);
  end

endmodule

// File: tb/tb_avl_rr_arbiter.sv
// Directed bench for avl_rr_arbiter with a transaction-level reference model
// (owner + tag queue) compared against the DUT on every falling edge.
module tb_avl_rr_arbiter;

  localparam int ADDR_W    = 26;
  localparam int DATA_W    = 128;
  localparam int MAX_OUTST = 8;

  logic              iCLK = 1'b0;
  logic              iRST_n;
  logic              local_init_done;
  logic [ADDR_W-1:0] r0_address, r1_address;
  logic [DATA_W-1:0] r0_writedata, r1_writedata;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic              r0_waitrequest_n, r1_waitrequest_n;
  logic              r0_readdatavalid, r1_readdatavalid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] avl_address;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_read, avl_write, avl_burstbegin;
  logic              avl_waitrequest_n, avl_readdatavalid;
  logic [DATA_W-1:0] avl_readdata;
  logic [$clog2(MAX_OUTST):0] outstanding;
  logic              err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  avl_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
    .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_read(r0_read),
    .r0_write(r0_write), .r0_waitrequest_n(r0_waitrequest_n), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_read(r1_read),
    .r1_write(r1_write), .r1_waitrequest_n(r1_waitrequest_n), .r1_readdatavalid(r1_readdatavalid),
    .rd_data(rd_data), .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_read(avl_read), .avl_write(avl_write), .avl_burstbegin(avl_burstbegin),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether this is its first grant cycle,
  // who won last, and the queue of issuers of reads still in flight.
  int  m_owner = -1;
  bit  m_fresh = 0;
  int  m_last  = 1;
  int  m_q[$];
  bit  m_err   = 0;
  bit  m_ok    = 0;

  always @(negedge iCLK) begin : model
    bit rq_r[2], rq_w[2];
    logic [ADDR_W-1:0] ra[2];
    logic [DATA_W-1:0] rw[2];
    bit e_rd, e_wr, e_cmd, acc, any0, any1;
    int own;
    rq_r[0] = r0_read;  rq_r[1] = r1_read;
    rq_w[0] = r0_write; rq_w[1] = r1_write;
    ra[0] = r0_address; ra[1] = r1_address;
    rw[0] = r0_writedata; rw[1] = r1_writedata;
    own   = (m_owner < 0) ? 0 : m_owner;
    e_wr  = (m_owner >= 0) && rq_w[own];
    e_rd  = (m_owner >= 0) && rq_r[own] && !rq_w[own] && (m_q.size() < MAX_OUTST);
    e_cmd = e_rd || e_wr;
    acc   = e_cmd && avl_waitrequest_n;
    if (m_ok) begin
      check("m_avl_write", avl_write, e_wr);
      check("m_avl_read", avl_read, e_rd);
      check("m_avl_address", avl_address, (m_owner >= 0) ? ra[own] : '0);
      check("m_avl_writedata", avl_writedata, (m_owner >= 0) ? rw[own] : '0);
      check("m_burstbegin", avl_burstbegin, m_fresh && e_cmd);
      check("m_r0_waitreq_n", r0_waitrequest_n, acc && m_owner == 0);
      check("m_r1_waitreq_n", r1_waitrequest_n, acc && m_owner == 1);
      check("m_r0_rdvalid", r0_readdatavalid, avl_readdatavalid && m_q.size() > 0 && m_q[0] == 0);
      check("m_r1_rdvalid", r1_readdatavalid, avl_readdatavalid && m_q.size() > 0 && m_q[0] == 1);
      check("m_rd_data", rd_data, avl_readdata);
      check("m_outstanding", outstanding, m_q.size());
      check("m_err_underflow", err_underflow, m_err);
    end
    if (!iRST_n) begin
      m_owner = -1; m_fresh = 0; m_last = 1; m_q.delete(); m_err = 0; m_ok = 1;
    end else if (m_ok) begin
      if (avl_readdatavalid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      any0 = r0_read || r0_write;
      any1 = r1_read || r1_write;
      if (m_owner >= 0) begin
        if (acc) begin
          if (e_rd) m_q.push_back(m_owner);
          m_last  = m_owner;
          m_owner = -1;
          m_fresh = 0;
        end else if (!rq_r[own] && !rq_w[own]) begin
          m_owner = -1;
          m_fresh = 0;
        end else begin
          m_fresh = 0;
        end
      end else if (local_init_done && (any0 || any1)) begin
        m_owner = (any0 && any1) ? 1 - m_last : (any0 ? 0 : 1);
        m_fresh = 1;
      end
    end
  end

  task automatic set_req(input int n, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (n == 0) begin r0_address = a; r0_writedata = d; r0_read = rd; r0_write = wr; end
    else        begin r1_address = a; r1_writedata = d; r1_read = rd; r1_write = wr; end
  endtask

  // Issue one request and hold it until accepted, then drop it.
  task automatic do_req(input int n, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    bit ok = 0;
    @(posedge iCLK); #1;
    set_req(n, !wr, wr, a, d);
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge iCLK);
      ok = (n == 0) ? r0_waitrequest_n : r1_waitrequest_n;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL do_req_timeout: requester %0d got no accept, required accept within 30 cycles", n);
    end
    @(posedge iCLK); #1;
    if (n == 0) begin r0_read = 0; r0_write = 0; end
    else        begin r1_read = 0; r1_write = 0; end
  endtask

  task automatic ret(input logic [DATA_W-1:0] d, output bit g0, output bit g1);
    @(posedge iCLK); #1;
    avl_readdatavalid = 1; avl_readdata = d;
    @(negedge iCLK);
    g0 = r0_readdatavalid; g1 = r1_readdatavalid;
    check("ret_rd_data", rd_data, d);
    @(posedge iCLK); #1;
    avl_readdatavalid = 0; avl_readdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g0, g1, a0, a1, done0, done1, seen;
    int grants[$];
    int gcyc[$];
    int first_acc;

    iRST_n = 0; local_init_done = 0;
    set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
    avl_waitrequest_n = 1; avl_readdatavalid = 0; avl_readdata = '0;

    // Reset state
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_avl_read", avl_read, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_underflow, 0);
    @(posedge iCLK); #1;
    iRST_n = 1; local_init_done = 1;

    // Single read from r0 with registered grant latency and routed return
    @(posedge iCLK); #1;
    set_req(0, 1, 0, 26'h10, '0);
    @(negedge iCLK);
    check("t1_idle_read", avl_read, 0);
    check("t1_idle_addr", avl_address, 0);
    @(posedge iCLK); #1;
    @(negedge iCLK);
    check("t1_avl_read", avl_read, 1);
    check("t1_avl_addr", avl_address, 26'h10);
    check("t1_burstbegin", avl_burstbegin, 1);
    check("t1_r0_waitreq_n", r0_waitrequest_n, 1);
    @(posedge iCLK); #1;
    r0_read = 0;
    @(negedge iCLK);
    check("t1_outstanding1", outstanding, 1);
    ret(128'hABCD, g0, g1);
    check("t1_r0_rdvalid", g0, 1);
    check("t1_r1_rdvalid", g1, 0);
    @(negedge iCLK);
    check("t1_outstanding0", outstanding, 0);

    // Both requesters write continuously: r0 won last, so r1 starts
    @(posedge iCLK); #1;
    set_req(0, 0, 1, 26'h20, 128'h1111);
    set_req(1, 0, 1, 26'h30, 128'h2222);
    for (int c = 0; c < 40 && grants.size() < 8; c++) begin
      @(negedge iCLK);
      if (r0_waitrequest_n) begin grants.push_back(0); gcyc.push_back(c); end
      if (r1_waitrequest_n) begin grants.push_back(1); gcyc.push_back(c); end
      if (grants.size() < 8) @(posedge iCLK);
    end
    @(posedge iCLK); #1;
    r0_write = 0; r1_write = 0;
    check("t2_grant_count", grants.size(), 8);
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("t2_grant%0d", i), grants[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check($sformatf("t2_gap%0d", i), gcyc[i] - gcyc[i-1], 2);
    end

    // Interleaved reads, in-order returns routed by tag
    do_req(0, 0, 26'h1, '0);
    do_req(1, 0, 26'h2, '0);
    do_req(0, 0, 26'h3, '0);
    @(negedge iCLK);
    check("t3_outstanding", outstanding, 3);
    ret(128'hA1, g0, g1); check("t3_ret0_r0", g0, 1); check("t3_ret0_r1", g1, 0);
    ret(128'hA2, g0, g1); check("t3_ret1_r0", g0, 0); check("t3_ret1_r1", g1, 1);
    ret(128'hA3, g0, g1); check("t3_ret2_r0", g0, 1); check("t3_ret2_r1", g1, 0);
    @(negedge iCLK);
    check("t3_err", err_underflow, 0);

    // Tag FIFO full: ninth read stalls until a return frees a slot
    for (int i = 0; i < MAX_OUTST; i++) do_req(0, 0, ADDR_W'(32'h100 + i), '0);
    @(negedge iCLK);
    check("t4_outstanding8", outstanding, 8);
    @(posedge iCLK); #1;
    set_req(1, 1, 0, 26'h200, '0);
    repeat (3) begin
      @(negedge iCLK);
      check("t4_full_read", avl_read, 0);
      check("t4_full_waitreq", r1_waitrequest_n, 0);
      @(posedge iCLK); #1;
    end
    avl_readdatavalid = 1; avl_readdata = 128'h55;
    @(negedge iCLK);
    check("t4_ret_read_masked", avl_read, 0);
    check("t4_ret_r0", r0_readdatavalid, 1);
    @(posedge iCLK); #1;
    avl_readdata = 128'h56;
    @(negedge iCLK);
    check("t4_read_released", avl_read, 1);
    check("t4_accept", r1_waitrequest_n, 1);
    check("t4_outstanding7", outstanding, 7);
    @(posedge iCLK); #1;
    avl_readdatavalid = 0; avl_readdata = '0; r1_read = 0;
    @(negedge iCLK);
    check("t4_pushpop_same", outstanding, 7);
    for (int i = 0; i < 7; i++) ret(128'h60 + i, g0, g1);
    check("t4_last_r0", g0, 0);
    check("t4_last_r1", g1, 1);

    // Underflow: return with nothing in flight
    ret(128'hDEAD, g0, g1);
    check("t5_uf_r0", g0, 0);
    check("t5_uf_r1", g1, 0);
    repeat (3) @(negedge iCLK);
    check("t5_err_sticky", err_underflow, 1);
    for (int i = 0; i < 3; i++) do_req(0, 0, ADDR_W'(32'h300 + i), '0);
    @(negedge iCLK);
    check("t5_outstanding3", outstanding, 3);
    check("t5_err_still", err_underflow, 1);
    @(posedge iCLK); #1; iRST_n = 0;
    @(posedge iCLK); #1;
    @(negedge iCLK);
    check("t5_rst_outstanding", outstanding, 0);
    check("t5_rst_err", err_underflow, 0);
    iRST_n = 1;
    ret(128'hBEEF, g0, g1);
    check("t5_late_r0", g0, 0);
    @(negedge iCLK);
    check("t5_late_err", err_underflow, 1);
    @(posedge iCLK); #1; iRST_n = 0;
    @(posedge iCLK); #1; iRST_n = 1;

    // No grants while calibration is incomplete
    @(posedge iCLK); #1;
    local_init_done = 0;
    set_req(0, 1, 0, 26'h40, '0);
    set_req(1, 0, 1, 26'h50, 128'h77);
    repeat (5) begin
      @(negedge iCLK);
      check("t6_no_read", avl_read, 0);
      check("t6_no_write", avl_write, 0);
      check("t6_stall0", r0_waitrequest_n, 0);
      check("t6_stall1", r1_waitrequest_n, 0);
      @(posedge iCLK); #1;
    end
    local_init_done = 1;
    first_acc = -1; done0 = 0; done1 = 0;
    for (int c = 0; c < 20 && !(done0 && done1); c++) begin
      @(negedge iCLK);
      a0 = r0_waitrequest_n; a1 = r1_waitrequest_n;
      @(posedge iCLK); #1;
      if (a0) begin r0_read = 0; done0 = 1; if (first_acc < 0) first_acc = 0; end
      if (a1) begin r1_write = 0; done1 = 1; if (first_acc < 0) first_acc = 1; end
    end
    check("t6_both_served", done0 && done1, 1);
    check("t6_first_is_r0", first_acc, 0);
    ret(128'h99, g0, g1);
    check("t6_ret_r0", g0, 1);

    // Calibration drops mid-grant: current transfer finishes, nothing new starts
    avl_waitrequest_n = 0;
    set_req(1, 0, 1, 26'h60, 128'h88);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge iCLK);
      seen = avl_write;
    end
    check("t7_granted", seen, 1);
    @(posedge iCLK); #1;
    local_init_done = 0;
    set_req(0, 1, 0, 26'h70, '0);
    @(negedge iCLK);
    check("t7_write_held", avl_write, 1);
    @(posedge iCLK); #1;
    avl_waitrequest_n = 1;
    @(negedge iCLK);
    check("t7_complete", r1_waitrequest_n, 1);
    @(posedge iCLK); #1;
    r1_write = 0;
    repeat (4) begin
      @(negedge iCLK);
      check("t7_no_new_read", avl_read, 0);
      @(posedge iCLK); #1;
    end
    local_init_done = 1;
    do_req(0, 0, 26'h70, '0);
    ret(128'h42, g0, g1);
    check("t7_ret_r0", g0, 1);

    repeat (2) @(negedge iCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
